// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states,
// opcode/funct values, datapath mux selects and the control bundle.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       orimm;
        logic       lui;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared memory port between controller (master) and memory (slave).
interface multicycle_controller_if;

    logic mem_req;
    logic memwrite;
    logic iord;
    logic mem_ready;

    modport master (
        output mem_req,
        output memwrite,
        output iord,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  memwrite,
        input  iord,
        output mem_ready
    );

endinterface

// File: rtl/mc_aludec.sv
// R-type funct decoder: ALU operation select plus a recognised-funct flag.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alucontrol,
    output logic       valid
);

    always_comb begin
        alucontrol = ALU_AND;
        valid      = 1'b1;
        unique case (funct)
            FN_ADD:  alucontrol = ALU_ADD;
            FN_SUB:  alucontrol = ALU_SUB;
            FN_AND:  alucontrol = ALU_AND;
            FN_OR:   alucontrol = ALU_OR;
            FN_SLT:  alucontrol = ALU_SLT;
            default: valid      = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller FSM with memory ready/timeout handling.
// Define MC_ORI_LUI_EN to decode ori/lui; otherwise they are illegal.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    multicycle_controller_if.master mem,
    output logic                 irwrite,
    output logic                 pcwrite,
    output logic [1:0]           pcsrc,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [2:0]           alucontrol,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 orimm,
    output logic                 lui,
    output logic                 illegal,
    output logic                 buserr,
    output logic [3:0]           state_o
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [5:0]  op_q;
    logic [5:0]  funct_q;
    logic [15:0] wait_cnt;
    logic        illegal_q;
    logic        buserr_q;
    logic [2:0]  fn_alu;
    logic        fn_ok;
    logic        expired;
    logic        imm_or;
    logic        imm_lui;
    logic [2:0]  imm_alu;
    ctrl_t       c;

    mc_aludec u_aludec (
        .funct      (funct_q),
        .alucontrol (fn_alu),
        .valid      (fn_ok)
    );

    assign expired = (wait_cnt == LAST);

    // wait_cnt defaults to clear so every state entry starts from zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_FETCH;
            op_q      <= '0;
            funct_q   <= '0;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            buserr_q  <= 1'b0;
        end else begin
            wait_cnt <= '0;
            unique case (state)
                S_FETCH: begin
                    if (mem.mem_ready) begin
                        state <= S_DECODE;
                    end else if (expired) begin
                        buserr_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_DECODE: begin
                    op_q    <= opcode;
                    funct_q <= funct;
                    case (opcode)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_R:         state <= S_EXEC;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_ADDI:      state <= S_IEXEC;
`ifdef MC_ORI_LUI_EN
                        OP_ORI, OP_LUI: state <= S_IEXEC;
`endif
                        OP_J:         state <= S_JUMP;
                        default: begin
                            illegal_q <= 1'b1;
                            state     <= S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    state <= (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem.mem_ready) begin
                        state <= S_MEMWB;
                    end else if (expired) begin
                        buserr_q <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_MEMWR: begin
                    if (mem.mem_ready) begin
                        state <= S_FETCH;
                    end else if (expired) begin
                        buserr_q <= 1'b1;
                        state    <= S_FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_EXEC: begin
                    if (fn_ok) begin
                        state <= S_ALUWB;
                    end else begin
                        illegal_q <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_IEXEC: state <= S_IWB;
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef MC_ORI_LUI_EN
    assign imm_or  = (op_q == OP_ORI);
    assign imm_lui = (op_q == OP_LUI);
`else
    assign imm_or  = 1'b0;
    assign imm_lui = 1'b0;
`endif

    assign imm_alu = imm_or  ? ALU_OR  :
                     imm_lui ? ALU_AND : ALU_ADD;

    always_comb begin
        c = '0;
        unique case (state)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alusrcb    = SRCB_FOUR;
                c.alucontrol = ALU_ADD;
                c.pcsrc      = PC_ALU;
                c.irwrite    = mem.mem_ready;
                c.pcwrite    = mem.mem_ready;
            end
            S_DECODE: begin
                c.alusrcb    = SRCB_IMMSH;
                c.alucontrol = ALU_ADD;
            end
            S_MEMADR: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_IMM;
                c.alucontrol = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req  = 1'b1;
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXEC: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_REGB;
                c.alucontrol = fn_alu;
            end
            S_ALUWB: begin
                c.regdst     = 1'b1;
                c.regwrite   = 1'b1;
                c.alucontrol = fn_alu;
            end
            S_BRANCH: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_REGB;
                c.alucontrol = ALU_SUB;
                c.pcsrc      = PC_ALUOUT;
                c.pcwrite    = zero;
            end
            S_IEXEC: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = SRCB_IMM;
                c.alucontrol = imm_alu;
                c.orimm      = imm_or;
                c.lui        = imm_lui;
            end
            S_IWB: begin
                c.regwrite   = 1'b1;
                c.alucontrol = imm_alu;
                c.orimm      = imm_or;
                c.lui        = imm_lui;
            end
            S_JUMP: begin
                c.pcsrc   = PC_JUMP;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        if (!reset) c = '0;
    end

    assign mem.mem_req  = c.mem_req;
    assign mem.memwrite = c.memwrite;
    assign mem.iord     = c.iord;
    assign irwrite      = c.irwrite;
    assign pcwrite      = c.pcwrite;
    assign pcsrc        = c.pcsrc;
    assign alusrca      = c.alusrca;
    assign alusrcb      = c.alusrcb;
    assign alucontrol   = c.alucontrol;
    assign regdst       = c.regdst;
    assign memtoreg     = c.memtoreg;
    assign regwrite     = c.regwrite;
    assign orimm        = c.orimm;
    assign lui          = c.lui;
    assign illegal      = reset & illegal_q;
    assign buserr       = reset & buserr_q;
    assign state_o      = reset ? state : 4'd0;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- FSM controller that sequences a multicycle MIPS datapath sharing one memory port for instruction fetch and data access.
- Replaces the per-instruction combinational decoder of the single-cycle core with a state machine that issues one micro-step per cycle.
- Stalls on a memory ready handshake, with a timeout.
- Sits beside the multicycle datapath inside the core top; drives all datapath enables and muxes.

Parameters:
- TIMEOUT, 255: max cycles a memory state waits for mem_ready before aborting (1..65535).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- opcode  in  6  instr[31:26] from datapath IR
- funct  in  6  instr[5:0] from datapath IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- memwrite  out  1  access is a write
- iord  out  1  address mux: 0=PC, 1=ALUOut
- irwrite  out  1  load instruction register
- pcwrite  out  1  load PC
- pcsrc  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
- alusrca  out  1  0=PC, 1=regA
- alusrcb  out  2  00=regB, 01=const 4, 10=signext imm, 11=signext imm<<2
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- regdst  out  1  dest: 0=rt, 1=rd
- memtoreg  out  1  writeback: 0=ALUOut, 1=MDR
- regwrite  out  1  register file write enable
- orimm  out  1  zero-extend immediate, OR operation
- lui  out  1  writeback imm<<16
- illegal  out  1  sticky, unknown opcode/funct seen
- buserr  out  1  sticky, memory timeout seen
- state_o  out  4  current state, debug

Behaviour:
- Reset (reset==0 at posedge): state=FETCH, op_q/funct_q=0, counter=0, illegal=buserr=0. While reset is low, all outputs are 0. FETCH outputs appear in the first cycle after release.
- Outputs are combinational from state, op_q/funct_q and zero. Signals not listed for a state are 0.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010, ori=001101, lui=001111.
- Funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, add, pcsrc=00. irwrite=pcwrite=mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: latch opcode/funct into op_q/funct_q. alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEMADR
  - R -> EXEC
  - beq -> BRANCH
  - addi/ori/lui -> IEXEC
  - j -> JUMP
  - other -> set illegal, go to FETCH
- MEMADR: alusrca=1, alusrcb=10, add. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_req=1, iord=1. On mem_ready -> MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: mem_req=1, iord=1, memwrite=1. On mem_ready -> FETCH.
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct_q -> ALUWB. Unknown funct: set illegal, go to FETCH, no writeback.
- ALUWB: regdst=1, regwrite=1, alucontrol still driven -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, pcwrite=zero -> FETCH.
- IEXEC: alusrca=1, alusrcb=10.
  - addi: add.
  - ori: or, orimm=1.
  - lui: lui=1.
  - -> IWB
- IWB: regdst=0, regwrite=1. orimm/lui/alucontrol held as in IEXEC -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- Memory states (FETCH, MEMRD, MEMWR):
  - Wait counter clears on entry and increments each cycle with mem_ready=0.
  - If the counter equals TIMEOUT-1 and mem_ready=0: set buserr, go to FETCH with counter cleared. FETCH re-fetches from the same PC. No irwrite, pcwrite or regwrite is issued for the aborted access.
  - mem_ready in the final counted cycle wins over timeout.
- mem_ready outside memory states is ignored.
- Reset low mid-operation (e.g. in MEMWR) aborts immediately: outputs are 0 that same cycle, and the next state is FETCH.
- illegal and buserr are cleared only by reset.

Optional Feature:
- Macro MC_ORI_LUI_EN.
- Defined: ori/lui are decoded as above.
- Undefined: ori/lui are illegal opcodes (set illegal, return to FETCH); orimm and lui are tied 0.

Decomposition:
- Package mc_pkg holds:
  - state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11
  - opcode and funct constants
  - alucontrol, alusrcb and pcsrc encodings
- One sub-module, mc_aludec: combinational funct_q -> alucontrol plus funct-valid flag.

Test Plan:
- lw with mem_ready delayed 2 cycles in FETCH and MEMRD -> FETCH holds 3 cycles, irwrite/pcwrite pulse once. Sequence FETCH,DECODE,MEMADR,MEMRD(x3),MEMWB; regwrite=1 with memtoreg=1 only in MEMWB.
- beq with zero=1, then zero=0 -> BRANCH pcwrite=1/pcsrc=01, then pcwrite=0. Both return to FETCH (4 states each, ready immediate).
- R-type funct=101010 -> EXEC alucontrol=111, ALUWB regdst=1 regwrite=1. funct=000111 -> illegal=1, no regwrite, next FETCH.
- opcode=111111 -> illegal rises after DECODE and stays 1 through following valid instructions until reset.
- TIMEOUT=4, sw with mem_ready never asserted in MEMWR -> after 4 MEMWR cycles buserr=1, state=FETCH; memwrite deasserted thereafter.
- Reset low during MEMWR with mem_ready=0 -> same cycle all outputs 0, state_o=0 after posedge; ori with MC_ORI_LUI_EN -> IEXEC orimm=1 alucontrol=001.
